dint: RTL and testbench
=======================

# dint

Sign-magnitude delayed-sum integrator: reconstructs a sample stream from the first differences produced by the differentiator stage, A(n) = C(n) + A(n-1). Sits downstream of the difference path in the anspwm chain and undoes the differentiation. The magnitude add/subtract rules are the mirror of the differentiator's. It adds a valid handshake, a synchronous clear, saturation control and a sticky saturation flag.

## Interface
- WIDTH, 16, magnitude width of input and output
- SAT_EN, 1, 1 = clamp magnitude at 2^WIDTH-1; 0 = magnitude wraps modulo 2^WIDTH
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- clr  in  1  synchronous clear of the accumulator and of sat
- in_valid  in  1  C/C_sign carry a difference sample this cycle
- C  in  WIDTH  difference magnitude
- C_sign  in  1  difference sign, 1 = negative
- A  out  WIDTH  reconstructed magnitude (registered)
- A_sign  out  1  reconstructed sign, 1 = negative (registered)
- out_valid  out  1  one-cycle pulse: A/A_sign updated by an accepted sample
- sat  out  1  sticky: a saturation or wrap event occurred since the last clr or reset

## Operation
- Reset value of every output is 0: A, A_sign, out_valid and sat.
- The accumulator is the A/A_sign register pair. There is no separate state.
- Accepted sample (in_valid=1, clr=0): the next A is A + C in sign-magnitude.
- Same signs: the magnitude sum is WIDTH+1 bits; the sign is kept.
- Different signs: the larger magnitude minus the smaller; the result takes the sign of the larger.
- Equal magnitudes with different signs give a zero result.
- Zero normalisation: any zero magnitude result forces A_sign=0 (no negative zero).
- Overflow applies only when the signs are the same and the sum exceeds 2^WIDTH-1.
  - SAT_EN=1: A=2^WIDTH-1, sign kept.
  - SAT_EN=0: A = sum[WIDTH-1:0], sign kept; if the truncated result is 0, A_sign=0.
  - In both modes sat sets to 1.
- sat is sticky: only clr or rst_n clears it.
- in_valid=0, clr=0: A, A_sign and sat hold; out_valid=0.
- clr=1, in_valid=0: next A=0, A_sign=0, sat=0, out_valid=0.
- clr=1, in_valid=1 (frame start): the accumulator loads C directly (0 + C).
  - A=C, A_sign=C_sign, with the zero normalisation applied.
  - sat=0, out_valid=1 next cycle.
  - This path cannot overflow.
- The input C=0 with C_sign=1 is treated as +0.
- No back-pressure: every in_valid cycle is accepted.

## Timing
- Latency is one cycle. An input sampled at edge k appears on A/A_sign at edge k, with out_valid=1 for the following cycle.
- Back-to-back in_valid is supported at full rate, one sample per clock, with out_valid continuously high.
- sat rises in the same cycle as the out_valid that carries the overflowed result.
- Asynchronous reset: asserting rst_n low at any time forces all outputs to 0 immediately, with no clock edge required, including mid-stream.
- On reset release, the first edge with in_valid=1 is accepted normally.
- The combinational path is a single WIDTH+1 add/subtract plus a compare and clamp feeding the registers.

## Test plan
- Reset check: hold rst_n=0, then release.
  - Required: A=0, A_sign=0, out_valid=0, sat=0 before and after release with idle inputs.
- Basic sequence with valid every cycle: C = +5, +3, -10, +2.
  - Required A/A_sign: 5/0, 8/0, 2/1, 0/0 (zero has sign 0); out_valid high for 4 cycles, each lagging its input by one.
- Inverse of the differentiator: feed differences +100, -60, -70, with gaps where in_valid=0 between samples.
  - Required A: 100/0, 40/0, 30/1.
  - Required during gaps: out_valid=0 and A holds.
- Saturation, SAT_EN=1: start from A=65530/0.
  - Add +10: required A=65535/0, sat=1.
  - Then -5: required A=65530/0, sat stays 1.
  - Then clr alone: required A=0, sat=0, out_valid=0.
- Wrap, SAT_EN=0: start from A=65530/0 and add +10.
  - Required A=4/0, sat=1.
- Clear with frame start: state A=300/0, then clr=1 and in_valid=1 with C=7/1.
  - Required A=7/1, sat=0, out_valid=1.
- Async reset mid-stream: drive rst_n low between clock edges while streaming.
  - Required: A, A_sign, out_valid and sat all 0 before the next rising edge.

Source files
------------

// File: rtl/dint.sv
// Sign-magnitude integrator A(n) = C(n) + A(n-1) with valid handshake,
// synchronous clear, optional magnitude saturation and sticky overflow flag.
module dint #(
    parameter int unsigned WIDTH  = 16,
    parameter bit          SAT_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] C,
    input  logic             C_sign,
    output logic [WIDTH-1:0] A,
    output logic             A_sign,
    output logic             out_valid,
    output logic             sat
);

    logic [WIDTH-1:0] a_q, a_d;
    logic             a_sign_q, a_sign_d;
    logic             vld_q, vld_d;
    logic             sat_q, sat_d;

    logic             c_neg;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] mag;
    logic             mag_sign;
    logic             ovf;

    // Single add/subtract path: same signs add, otherwise larger minus smaller.
    always_comb begin
        c_neg    = C_sign & (C != '0);
        sum      = {1'b0, a_q} + {1'b0, C};
        ovf      = 1'b0;
        mag      = sum[WIDTH-1:0];
        mag_sign = a_sign_q;
        if (a_sign_q == c_neg) begin
            ovf = sum[WIDTH];
            if (ovf && SAT_EN) begin
                mag = '1;
            end
        end else if (a_q >= C) begin
            mag      = a_q - C;
            mag_sign = a_sign_q;
        end else begin
            mag      = C - a_q;
            mag_sign = c_neg;
        end
    end

    always_comb begin
        a_d      = a_q;
        a_sign_d = a_sign_q;
        sat_d    = sat_q;
        vld_d    = 1'b0;
        if (clr) begin
            sat_d    = 1'b0;
            vld_d    = in_valid;
            a_d      = in_valid ? C : '0;
            a_sign_d = in_valid & c_neg;
        end else if (in_valid) begin
            vld_d    = 1'b1;
            a_d      = mag;
            a_sign_d = mag_sign & (mag != '0);
            sat_d    = sat_q | ovf;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            a_sign_q <= 1'b0;
            vld_q    <= 1'b0;
            sat_q    <= 1'b0;
        end else begin
            a_q      <= a_d;
            a_sign_q <= a_sign_d;
            vld_q    <= vld_d;
            sat_q    <= sat_d;
        end
    end

    assign A         = a_q;
    assign A_sign    = a_sign_q;
    assign out_valid = vld_q;
    assign sat       = sat_q;

endmodule

// File: tb/tb_dint.sv
// Scoreboard bench for dint: a saturating and a wrapping instance share stimulus,
// each checked against a signed-integer reference model.
module tb_dint;

    localparam int W    = 16;
    localparam int MAXV = (1 << W) - 1;

    logic         clk;
    logic         rst_n;
    logic         clr;
    logic         in_valid;
    logic [W-1:0] C;
    logic         C_sign;

    logic [W-1:0] a1, a0;
    logic         s1, s0, v1, v0, t1, t0;

    int checks   = 0;
    int failures = 0;

    int acc [2];
    bit st  [2];
    logic [W+1:0] q1 [$];
    logic [W+1:0] q0 [$];

    dint #(.WIDTH(W), .SAT_EN(1'b1)) u_sat (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid),
        .C(C), .C_sign(C_sign), .A(a1), .A_sign(s1), .out_valid(v1), .sat(t1)
    );

    dint #(.WIDTH(W), .SAT_EN(1'b0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid),
        .C(C), .C_sign(C_sign), .A(a0), .A_sign(s0), .out_valid(v0), .sat(t0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W+1:0] pack(input int value, input bit flag);
        int          m;
        logic [W-1:0] mw;
        m  = (value < 0) ? -value : value;
        mw = m[W-1:0];
        return {flag, (value < 0), mw};
    endfunction

    // i = 1: saturating model, i = 0: wrapping model
    function automatic void model(input int i, input bit v, input bit c, input int mag, input bit sg);
        int cv, n, absn;
        cv = sg ? -mag : mag;
        if (c) begin
            st[i]  = 1'b0;
            acc[i] = v ? cv : 0;
        end else if (v) begin
            n    = acc[i] + cv;
            absn = (n < 0) ? -n : n;
            if (absn > MAXV) begin
                st[i] = 1'b1;
                absn  = (i == 1) ? MAXV : (absn % (MAXV + 1));
            end
            acc[i] = (n < 0) ? -absn : absn;
        end
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input bit v, input bit c, input int mag, input bit sg);
        @(posedge clk);
        #1;
        in_valid = v;
        clr      = c;
        C        = mag[W-1:0];
        C_sign   = sg;
        model(1, v, c, mag, sg);
        model(0, v, c, mag, sg);
        if (v) begin
            q1.push_back(pack(acc[1], st[1]));
            q0.push_back(pack(acc[0], st[0]));
        end
    endtask

    // Idles the inputs, then checks the result of the previously driven cycle.
    task automatic expect_c(input string name, input int ea1, input bit es1, input bit et1,
                            input int ea0, input bit es0, input bit et0, input bit ov);
        step(0, 0, 0, 0);
        @(negedge clk);
        chk({name, "_sat"},  {v1, t1, s1, a1}, {ov, et1, es1, ea1[W-1:0]});
        chk({name, "_wrap"}, {v0, t0, s0, a0}, {ov, et0, es0, ea0[W-1:0]});
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_sat"},  {v1, t1, s1, a1}, 0);
        chk({name, "_wrap"}, {v0, t0, s0, a0}, 0);
    endtask

    always @(negedge clk) begin
        if (v1) begin
            if (q1.size() == 0) begin
                checks++; failures++;
                $display("FAIL sb_sat: unexpected out_valid A=%0d", a1);
            end else begin
                chk("sb_sat", {t1, s1, a1}, q1.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (v0) begin
            if (q0.size() == 0) begin
                checks++; failures++;
                $display("FAIL sb_wrap: unexpected out_valid A=%0d", a0);
            end else begin
                chk("sb_wrap", {t0, s0, a0}, q0.pop_front());
            end
        end
    end

    initial begin
        int mag;
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; C = '0; C_sign = 1'b0;
        acc[0] = 0; acc[1] = 0; st[0] = 0; st[1] = 0;

        repeat (3) @(negedge clk);
        chk_zero("reset_hold");
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk_zero("reset_release");

        step(1, 0, 5, 0); step(1, 0, 3, 0); step(1, 0, 10, 1); step(1, 0, 2, 0);
        expect_c("basic_last", 0, 0, 0, 0, 0, 0, 1);

        step(1, 0, 100, 0);
        expect_c("inv_100", 100, 0, 0, 100, 0, 0, 1);
        expect_c("gap_hold", 100, 0, 0, 100, 0, 0, 0);
        step(1, 0, 60, 1);
        expect_c("inv_40", 40, 0, 0, 40, 0, 0, 1);
        step(1, 0, 70, 1);
        expect_c("inv_m30", 30, 1, 0, 30, 1, 0, 1);

        step(1, 1, 65530, 0);
        step(1, 0, 10, 0);
        expect_c("ovf_add", 65535, 0, 1, 4, 0, 1, 1);
        step(1, 0, 5, 1);
        expect_c("ovf_sub", 65530, 0, 1, 1, 1, 1, 1);
        step(0, 1, 0, 0);
        expect_c("clr_only", 0, 0, 0, 0, 0, 0, 0);

        step(1, 1, 300, 0);
        step(1, 1, 7, 1);
        expect_c("frame_start", 7, 1, 0, 7, 1, 0, 1);
        step(1, 1, 0, 1);
        expect_c("neg_zero", 0, 0, 0, 0, 0, 0, 1);

        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) begin
                step(1, 0, 1234, 0);
                #2 rst_n = 1'b0;
                #1 chk_zero("async_reset");
                in_valid = 1'b0; clr = 1'b0;
                q1.delete(); q0.delete();
                acc[0] = 0; acc[1] = 0; st[0] = 0; st[1] = 0;
                @(posedge clk); #1 rst_n = 1'b1;
            end
            case ($urandom_range(0, 3))
                0:       mag = 0;
                1:       mag = $urandom_range(MAXV - 40, MAXV);
                default: mag = $urandom_range(0, MAXV);
            endcase
            step($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, mag, $urandom_range(0, 1) == 1);
        end

        step(0, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("drain_sat", q1.size(), 0);
        chk("drain_wrap", q0.size(), 0);
        chk("final_sat", {t1, s1, a1}, pack(acc[1], st[1]));
        chk("final_wrap", {t0, s0, a0}, pack(acc[0], st[0]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
